dmem_ctrl: RTL



---
 rtl/dmem_ctrl_pkg.sv | 23 ++
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ctrl_sram_pad.sv | 35 +++
 rtl/dmem_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared CPU memory definitions: FSM encodings, SRAM strobe levels, bus widths.
// Shared by the data-memory controller and the Ram2 instruction-fetch controller.
package cpu_defs;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int CPU_AW     = 16;

  localparam logic STB_IDLE = 1'b1;
  localparam logic STB_ACT  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WSETUP = 3'd2,
    ST_WPULSE = 3'd3,
    ST_WHOLD  = 3'd4,
    ST_DONE   = 3'd5
  } dmem_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// EX/MEM-side request/response bundle of the data-memory controller.
// master = pipeline, slave = controller.
interface dmem_ctrl_if;
  import cpu_defs::*;

  logic                  memread_i;
  logic                  memwrite_i;
  logic [CPU_AW-1:0]     addr_i;
  logic [DATA_W_DEF-1:0] wdata_i;
  logic [DATA_W_DEF-1:0] rdata_o;
  logic                  stall_o;
  logic                  done_o;

  modport master (
    output memread_i, memwrite_i, addr_i, wdata_i,
    input  rdata_o, stall_o, done_o
  );

  modport slave (
    input  memread_i, memwrite_i, addr_i, wdata_i,
    output rdata_o, stall_o, done_o
  );
endinterface

// File: rtl/dmem_ctrl_sram_pad.sv
// SRAM data pad: registered tristate driver plus registered input sample.
// Drive enable is registered from the controller's next state so it is glitch-free.
module sram_pad
  import cpu_defs::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drv_en_nxt,
  input  logic              i_dout_ld,
  input  logic [DATA_W-1:0] i_dout,
  input  logic              i_smp_en,
  output logic [DATA_W-1:0] o_din,
  inout  wire  [DATA_W-1:0] io_pad
);
  logic              r_drv_en;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] r_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drv_en <= 1'b0;
      r_dout   <= '0;
      r_din    <= '0;
    end else begin
      r_drv_en <= i_drv_en_nxt;
      if (i_dout_ld) r_dout <= i_dout;
      if (i_smp_en)  r_din  <= io_pad;
    end
  end

  assign io_pad = r_drv_en ? r_dout : {DATA_W{1'bz}};
  assign o_din  = r_din;
endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: sequences single-cycle load/store requests onto Ram1.
// Stalls the pipeline until the access reaches DONE; load data returned on rdata_o.
module dmem_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN
);
  localparam int CNT_W = $clog2(max2(RD_WAIT, WR_WAIT)) + 1;

  dmem_state_t       r_state, w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              w_req, w_last, w_drv_nxt, w_smp, w_ld;
  logic [DATA_W-1:0] w_rdata;

  assign w_req  = bus.memread_i | bus.memwrite_i;
  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        // Write wins when both requests are raised together.
        if (bus.memwrite_i)     w_nxt = ST_WSETUP;
        else if (bus.memread_i) w_nxt = ST_RD;
      end
      ST_RD:     if (w_last) w_nxt = ST_DONE;
      ST_WSETUP: w_nxt = ST_WPULSE;
      ST_WPULSE: if (w_last) w_nxt = ST_WHOLD;
      ST_WHOLD:  w_nxt = ST_DONE;
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Ram1EN     = STB_IDLE;
    Ram1OE     = STB_IDLE;
    Ram1WE     = STB_IDLE;
    bus.done_o = 1'b0;
    case (r_state)
      ST_RD: begin
        Ram1EN = STB_ACT;
        Ram1OE = STB_ACT;
      end
      ST_WSETUP, ST_WHOLD: Ram1EN = STB_ACT;
      ST_WPULSE: begin
        Ram1EN = STB_ACT;
        Ram1WE = STB_ACT;
      end
      ST_DONE: bus.done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.stall_o = ((r_state == ST_IDLE) && w_req) ||
                       ((r_state != ST_IDLE) && (r_state != ST_DONE));

  // Wait counter reloads on each state entry and counts down to zero without wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_nxt != r_state) begin
      case (w_nxt)
        ST_RD:     r_cnt <= CNT_W'(RD_WAIT - 1);
        ST_WPULSE: r_cnt <= CNT_W'(WR_WAIT - 1);
        default:   r_cnt <= '0;
      endcase
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_addr <= '0;
    else if ((r_state == ST_IDLE) && w_req) r_addr <= ADDR_W'(bus.addr_i);
  end

  assign Ram1Addr  = r_addr;
  assign w_drv_nxt = (w_nxt == ST_WSETUP) || (w_nxt == ST_WPULSE) || (w_nxt == ST_WHOLD);
  assign w_ld      = (r_state == ST_IDLE) && bus.memwrite_i;
  assign w_smp     = (r_state == ST_RD) && w_last;

  sram_pad #(.DATA_W(DATA_W)) u_pad (
    .clk          (clk),
    .rst          (rst),
    .i_drv_en_nxt (w_drv_nxt),
    .i_dout_ld    (w_ld),
    .i_dout       (bus.wdata_i),
    .i_smp_en     (w_smp),
    .o_din        (w_rdata),
    .io_pad       (Ram1Data)
  );

  assign bus.rdata_o = w_rdata;
endmodule
